// File: rtl/param_cpu_core.sv
// param_cpu_core: a small parameterised accumulator-style CPU core.
// The core fetches one instruction over a request/acknowledge port, runs it
// for one cycle and then fetches the next one. HALT stops the core until reset.
// An instruction is {opcode[3:0], rd[RB-1:0], field[DW-1:0]}. Its source
// register is field[RB-1:0] and its immediate is field.
// Optional feature: define CPU_CARRY_EN to add the carry flag, ADC (12) and
// JC (13). When CPU_CARRY_EN is not defined, opcodes 12-14 execute as NOP.
// Parameter constraints: DW >= 4, AW <= DW.

module param_cpu_core #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int RB = 4,
  localparam int IW = 4 + RB + DW
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] ir,
  output logic [AW-1:0] pc,
  output logic          wb_valid,
  output logic [RB-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          halted
);

  localparam int NREG = 1 << RB;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_JZ   = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_HALT = 4'd15;
`ifdef CPU_CARRY_EN
  localparam logic [3:0] OP_ADC  = 4'd12;
  localparam logic [3:0] OP_JC   = 4'd13;
`endif

  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Architectural and output state
  state_t        state_r;
  logic          req_r;
  logic [AW-1:0] pc_r;
  logic [IW-1:0] ir_r;
  logic          wb_valid_r;
  logic [RB-1:0] wb_addr_r;
  logic [DW-1:0] wb_data_r;
  logic          halted_r;
  logic [DW-1:0] regs_r [NREG];

  // Decoded fields of the instruction being executed
  logic [3:0]    opcode_s;
  logic [RB-1:0] rd_s;
  logic [DW-1:0] field_s;
  logic [RB-1:0] rs_s;
  logic [AW-1:0] target_s;
  logic [DW-1:0] rd_val_s;
  logic [DW-1:0] rs_val_s;
  logic [AW-1:0] pc_inc_s;

  // Results of the execute stage
  logic [DW-1:0] result_s;
  logic          wr_en_s;
  logic [AW-1:0] pc_next_s;
  logic          halt_s;

  assign opcode_s = ir_r[IW-1 -: 4];
  assign rd_s     = ir_r[DW +: RB];
  assign field_s  = ir_r[DW-1:0];
  assign rs_s     = field_s[RB-1:0];
  assign target_s = field_s[AW-1:0];
  // Both operands come from the register file as it stands during EXEC.
  // This means rd == rs sees the old value.
  assign rd_val_s = regs_r[rd_s];
  assign rs_val_s = regs_r[rs_s];
  assign pc_inc_s = pc_r + PC_ONE;

`ifdef CPU_CARRY_EN
  logic          carry_r;
  logic          carry_next_s;
  logic [DW:0]   add_ext_s;
  logic [DW:0]   sub_ext_s;
  logic [DW:0]   adc_ext_s;

  // The widened sums expose the carry-out. In sub_ext_s the top bit is the borrow.
  assign add_ext_s = {1'b0, rd_val_s} + {1'b0, rs_val_s};
  assign sub_ext_s = {1'b0, rd_val_s} - {1'b0, rs_val_s};
  assign adc_ext_s = add_ext_s + {{DW{1'b0}}, carry_r};
`endif

  // Decode and execute the current instruction: result, write enable, next pc
  always_comb begin
    result_s  = rd_val_s;
    wr_en_s   = 1'b0;
    pc_next_s = pc_inc_s;
    halt_s    = 1'b0;
`ifdef CPU_CARRY_EN
    carry_next_s = carry_r;
`endif
    case (opcode_s)
      OP_NOP: begin
        wr_en_s = 1'b0;
      end
      OP_LDI: begin
        result_s = field_s;
        wr_en_s  = 1'b1;
      end
      OP_ADD: begin
`ifdef CPU_CARRY_EN
        result_s     = add_ext_s[DW-1:0];
        carry_next_s = add_ext_s[DW];
`else
        result_s = rd_val_s + rs_val_s;
`endif
        wr_en_s = 1'b1;
      end
      OP_SUB: begin
`ifdef CPU_CARRY_EN
        result_s     = sub_ext_s[DW-1:0];
        carry_next_s = sub_ext_s[DW];
`else
        result_s = rd_val_s - rs_val_s;
`endif
        wr_en_s = 1'b1;
      end
      OP_AND: begin
        result_s = rd_val_s & rs_val_s;
        wr_en_s  = 1'b1;
      end
      OP_OR: begin
        result_s = rd_val_s | rs_val_s;
        wr_en_s  = 1'b1;
      end
      OP_XOR: begin
        result_s = rd_val_s ^ rs_val_s;
        wr_en_s  = 1'b1;
      end
      OP_MOV: begin
        result_s = rs_val_s;
        wr_en_s  = 1'b1;
      end
      OP_JMP: begin
        pc_next_s = target_s;
      end
      OP_JZ: begin
        if (rd_val_s == {DW{1'b0}}) begin
          pc_next_s = target_s;
        end else begin
          pc_next_s = pc_inc_s;
        end
      end
      OP_SHL: begin
        result_s = {rd_val_s[DW-2:0], 1'b0};
`ifdef CPU_CARRY_EN
        carry_next_s = rd_val_s[DW-1];
`endif
        wr_en_s = 1'b1;
      end
      OP_SHR: begin
        result_s = {1'b0, rd_val_s[DW-1:1]};
        wr_en_s  = 1'b1;
      end
`ifdef CPU_CARRY_EN
      OP_ADC: begin
        result_s     = adc_ext_s[DW-1:0];
        carry_next_s = adc_ext_s[DW];
        wr_en_s      = 1'b1;
      end
      OP_JC: begin
        if (carry_r) begin
          pc_next_s = target_s;
        end else begin
          pc_next_s = pc_inc_s;
        end
      end
`endif
      OP_HALT: begin
        pc_next_s = pc_r;
        halt_s    = 1'b1;
      end
      default: begin
        // Unused opcodes behave as NOP: no register write, pc advances.
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Control FSM with the register file, pc, ir and write-back outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_FETCH;
      req_r      <= 1'b0;
      pc_r       <= {AW{1'b0}};
      ir_r       <= {IW{1'b0}};
      wb_valid_r <= 1'b0;
      wb_addr_r  <= {RB{1'b0}};
      wb_data_r  <= {DW{1'b0}};
      halted_r   <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
    end else begin
      case (state_r)
        ST_FETCH: begin
          wb_valid_r <= 1'b0;
          // The acknowledge is sampled only while a request is actually raised.
          // This drops any stale acknowledge left over from before a reset.
          if (req_r && imem_ack) begin
            ir_r    <= imem_rdata;
            req_r   <= 1'b0;
            state_r <= ST_EXEC;
          end else begin
            req_r <= 1'b1;
          end
        end
        ST_EXEC: begin
          pc_r       <= pc_next_s;
          wb_valid_r <= wr_en_s;
          if (wr_en_s) begin
            regs_r[rd_s] <= result_s;
            wb_addr_r    <= rd_s;
            wb_data_r    <= result_s;
          end
          if (halt_s) begin
            halted_r <= 1'b1;
            req_r    <= 1'b0;
            state_r  <= ST_HALT;
          end else begin
            req_r   <= 1'b1;
            state_r <= ST_FETCH;
          end
        end
        ST_HALT: begin
          wb_valid_r <= 1'b0;
          req_r      <= 1'b0;
        end
        default: begin
          state_r <= ST_FETCH;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

`ifdef CPU_CARRY_EN
  // Carry flag, updated only when an arithmetic instruction retires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_r <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      carry_r <= carry_next_s;
    end else begin
      carry_r <= carry_r;
    end
  end
`endif

  assign imem_req  = req_r;
  assign imem_addr = pc_r;
  assign ir        = ir_r;
  assign pc        = pc_r;
  assign wb_valid  = wb_valid_r;
  assign wb_addr   = wb_addr_r;
  assign wb_data   = wb_data_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_param_cpu_core.sv
// Directed testbench for param_cpu_core with the default parameters (8/8/4).
// The bench models the instruction memory as an array. Each fetch is
// acknowledged after a programmable number of wait cycles.

module tb_param_cpu_core;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RB = 4;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_rdata = 16'h0000;
  logic [IW-1:0] ir;
  logic [AW-1:0] pc;
  logic          wb_valid;
  logic [RB-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          halted;

  logic [IW-1:0] mem [256];
  int ack_delay = 0;
  int wait_cnt = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int wb_a_q[$];
  int wb_d_q[$];
  int wb_c_q[$];
  int fa_q[$];

  param_cpu_core #(.DW(DW), .AW(AW), .RB(RB)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .pc(pc),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] f);
    return {op, rd, f};
  endfunction

  // Memory responder: it drives ack/rdata shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (imem_req) begin
        imem_ack   = (wait_cnt >= ack_delay);
        imem_rdata = mem[imem_addr];
        wait_cnt   = wait_cnt + 1;
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Log accepted fetch addresses and write-back pulses
  always @(negedge clk) begin
    if (!reset && imem_req && imem_ack) fa_q.push_back(int'(imem_addr));
    if (!reset && wb_valid) begin
      wb_a_q.push_back(int'(wb_addr));
      wb_d_q.push_back(int'(wb_data));
      wb_c_q.push_back(cyc);
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    fa_q.delete(); wb_a_q.delete(); wb_d_q.delete(); wb_c_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output bit ok);
    int i;
    i = 0;
    while (!halted && i < budget) begin
      @(negedge clk);
      i++;
    end
    ok = halted;
  endtask

  task automatic test_reset();
    clear_mem();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL rst_pc: got %h want 00", pc); end
    n_cmp++; if (ir !== 16'h0000) begin n_bad++; $display("FAIL rst_ir: got %h want 0000", ir); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wbv: got %b want 0", wb_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b want 0", halted); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rst_first_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 8'h00) begin n_bad++; $display("FAIL rst_first_addr: got %h want 00", imem_addr); end
  endtask

  task automatic test_basic();
    int exp_a[3] = '{1, 2, 1};
    int exp_d[3] = '{8'h05, 8'h03, 8'h08};
    bit ok;
    clear_mem();
    mem[0] = ins(4'd1, 4'd1, 8'h05);
    mem[1] = ins(4'd1, 4'd2, 8'h03);
    mem[2] = ins(4'd2, 4'd1, 8'h02);
    mem[3] = ins(4'd15, 4'd0, 8'h00);
    ack_delay = 0;
    do_reset();
    wait_halt(60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_halt: halted=%b want 1", halted); end
    n_cmp++; if (wb_a_q.size() !== 3) begin n_bad++; $display("FAIL basic_wb_count: got %0d want 3", wb_a_q.size()); end
    for (int i = 0; i < 3 && i < wb_a_q.size(); i++) begin
      n_cmp++;
      if (wb_a_q[i] !== exp_a[i] || wb_d_q[i] !== exp_d[i]) begin
        n_bad++; $display("FAIL basic_wb%0d: got (%0d,%h) want (%0d,%h)", i, wb_a_q[i], wb_d_q[i], exp_a[i], exp_d[i]);
      end
    end
    for (int i = 1; i < 3 && i < wb_c_q.size(); i++) begin
      n_cmp++;
      if (wb_c_q[i] - wb_c_q[i-1] !== 2) begin
        n_bad++; $display("FAIL basic_gap%0d: got %0d cycles want 2", i, wb_c_q[i] - wb_c_q[i-1]);
      end
    end
    n_cmp++; if (pc !== 8'h03) begin n_bad++; $display("FAIL basic_pc: got %h want 03", pc); end
  endtask

  task automatic test_alu();
    int exp_a[10] = '{1, 2, 1, 1, 1, 4, 4, 4, 4, 5};
    int exp_d[10] = '{8'hA5, 8'h3C, 8'h24, 8'h3C, 8'h00, 8'h10, 8'hD4, 8'hA8, 8'h54, 8'h3C};
    bit ok;
    clear_mem();
    mem[0]  = ins(4'd1, 4'd1, 8'hA5);
    mem[1]  = ins(4'd1, 4'd2, 8'h3C);
    mem[2]  = ins(4'd4, 4'd1, 8'h02);
    mem[3]  = ins(4'd5, 4'd1, 8'h02);
    mem[4]  = ins(4'd6, 4'd1, 8'h02);
    mem[5]  = ins(4'd1, 4'd4, 8'h10);
    mem[6]  = ins(4'd3, 4'd4, 8'h02);
    mem[7]  = ins(4'd10, 4'd4, 8'h00);
    mem[8]  = ins(4'd11, 4'd4, 8'h00);
    mem[9]  = ins(4'd7, 4'd5, 8'h02);
    mem[10] = ins(4'd14, 4'd6, 8'h55);
    mem[11] = ins(4'd15, 4'd0, 8'h00);
    ack_delay = 0;
    do_reset();
    wait_halt(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL alu_halt: halted=%b want 1", halted); end
    n_cmp++; if (wb_a_q.size() !== 10) begin n_bad++; $display("FAIL alu_wb_count: got %0d want 10", wb_a_q.size()); end
    for (int i = 0; i < 10 && i < wb_a_q.size(); i++) begin
      n_cmp++;
      if (wb_a_q[i] !== exp_a[i] || wb_d_q[i] !== exp_d[i]) begin
        n_bad++; $display("FAIL alu_wb%0d: got (%0d,%h) want (%0d,%h)", i, wb_a_q[i], wb_d_q[i], exp_a[i], exp_d[i]);
      end
    end
    n_cmp++; if (pc !== 8'h0B) begin n_bad++; $display("FAIL alu_pc: got %h want 0b", pc); end
  endtask

  task automatic test_carry();
    int exp_next;
    bit ok;
`ifdef CPU_CARRY_EN
    exp_next = 8'h20;
`else
    exp_next = 8'h03;
`endif
    clear_mem();
    mem[0]     = ins(4'd1, 4'd3, 8'hFF);
    mem[1]     = ins(4'd2, 4'd3, 8'h03);
    mem[2]     = ins(4'd13, 4'd0, 8'h20);
    mem[3]     = ins(4'd15, 4'd0, 8'h00);
    mem[8'h20] = ins(4'd15, 4'd0, 8'h00);
    ack_delay = 0;
    do_reset();
    wait_halt(60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL carry_halt: halted=%b want 1", halted); end
    n_cmp++; if (wb_d_q.size() < 2 || wb_d_q[1] !== 8'hFE) begin n_bad++; $display("FAIL carry_double: got %0d writes want data fe", wb_d_q.size()); end
    n_cmp++; if (fa_q.size() < 4 || fa_q[3] !== exp_next) begin n_bad++; $display("FAIL carry_jc_addr: got %0d fetches want 4th at %h", fa_q.size(), exp_next); end
  endtask

  task automatic test_jz();
    int exp_f[5] = '{8'h00, 8'h01, 8'h40, 8'h41, 8'h42};
    bit ok;
    clear_mem();
    mem[0]     = ins(4'd1, 4'd0, 8'h00);
    mem[1]     = ins(4'd9, 4'd0, 8'h40);
    mem[8'h40] = ins(4'd1, 4'd0, 8'h01);
    mem[8'h41] = ins(4'd9, 4'd0, 8'h10);
    mem[8'h42] = ins(4'd15, 4'd0, 8'h00);
    mem[8'h10] = ins(4'd15, 4'd0, 8'h00);
    ack_delay = 0;
    do_reset();
    wait_halt(60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL jz_halt: halted=%b want 1", halted); end
    n_cmp++; if (fa_q.size() !== 5) begin n_bad++; $display("FAIL jz_fetch_count: got %0d want 5", fa_q.size()); end
    for (int i = 0; i < 5 && i < fa_q.size(); i++) begin
      n_cmp++;
      if (fa_q[i] !== exp_f[i]) begin n_bad++; $display("FAIL jz_fetch%0d: got %h want %h", i, fa_q[i], exp_f[i]); end
    end
  endtask

  task automatic test_wait_wrap();
    int exp_f[5] = '{8'h00, 8'hFE, 8'hFF, 8'h00, 8'h01};
    bit ok;
    clear_mem();
    mem[0]     = ins(4'd9, 4'd7, 8'hFE);
    mem[8'hFE] = ins(4'd1, 4'd7, 8'h01);
    mem[8'hFF] = ins(4'd0, 4'd0, 8'h00);
    mem[1]     = ins(4'd15, 4'd0, 8'h00);
    ack_delay = 3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || pc !== 8'h00 || ir !== 16'h0000) begin
        n_bad++; $display("FAIL wait_hold%0d: req=%b pc=%h ir=%h want 1/00/0000", i, imem_req, pc, ir);
      end
    end
    @(negedge clk);
    n_cmp++; if (ir !== 16'h97FE || imem_req !== 1'b0) begin n_bad++; $display("FAIL wait_accept: ir=%h req=%b want 97fe/0", ir, imem_req); end
    wait_halt(200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_halt: halted=%b want 1", halted); end
    n_cmp++; if (fa_q.size() !== 5) begin n_bad++; $display("FAIL wrap_fetch_count: got %0d want 5", fa_q.size()); end
    for (int i = 0; i < 5 && i < fa_q.size(); i++) begin
      n_cmp++;
      if (fa_q[i] !== exp_f[i]) begin n_bad++; $display("FAIL wrap_fetch%0d: got %h want %h", i, fa_q[i], exp_f[i]); end
    end
  endtask

  task automatic test_halt();
    bit ok;
    clear_mem();
    mem[7] = ins(4'd15, 4'd0, 8'h00);
    ack_delay = 0;
    do_reset();
    wait_halt(60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL halt_reach: halted=%b want 1", halted); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (pc !== 8'h07 || halted !== 1'b1 || imem_req !== 1'b0) begin
        n_bad++; $display("FAIL halt_hold%0d: pc=%h halted=%b req=%b want 07/1/0", i, pc, halted, imem_req);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int i;
    bit ok;
    clear_mem();
    mem[0] = ins(4'd1, 4'd4, 8'h5A);
    mem[1] = ins(4'd15, 4'd0, 8'h00);
    ack_delay = 0;
    do_reset();
    i = 0;
    while (!(imem_req && imem_ack) && i < 20) begin
      @(negedge clk);
      i++;
    end
    ack_delay = 10;
    repeat (4) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || pc !== 8'h01 || wb_data !== 8'h5A) begin
      n_bad++; $display("FAIL midwait_pre: req=%b pc=%h wbd=%h want 1/01/5a", imem_req, pc, wb_data);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || pc !== 8'h00 || ir !== 16'h0000) begin
      n_bad++; $display("FAIL midwait_rst_a: req=%b pc=%h ir=%h want 0/00/0000", imem_req, pc, ir);
    end
    n_cmp++; if (wb_valid !== 1'b0 || wb_addr !== 4'h0 || wb_data !== 8'h00 || halted !== 1'b0) begin
      n_bad++; $display("FAIL midwait_rst_b: wbv=%b wba=%h wbd=%h halted=%b want all 0", wb_valid, wb_addr, wb_data, halted);
    end
    mem[0] = ins(4'd7, 4'd6, 8'h04);
    ack_delay = 0;
    do_reset();
    wait_halt(60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL midwait_halt: halted=%b want 1", halted); end
    n_cmp++; if (fa_q.size() < 1 || fa_q[0] !== 0) begin n_bad++; $display("FAIL midwait_refetch: got %0d fetches want first at 00", fa_q.size()); end
    n_cmp++; if (wb_a_q.size() !== 1 || wb_a_q[0] !== 6 || wb_d_q[0] !== 0) begin
      n_bad++; $display("FAIL midwait_regs_cleared: got %0d writes want one (6,00)", wb_a_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alu();
    test_carry();
    test_jz();
    test_wait_wrap();
    test_halt();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
